// File: rtl/spi_request_arbiter_if.sv
// Link between spi_request_arbiter (master modport) and the shared SPI master
// (slave modport): load/start strobes, transfer config and the read-back byte.
interface spi_request_arbiter_if;
    logic       m_load;
    logic       m_start;
    logic [7:0] m_data_to_write;
    logic [1:0] m_slave_address;
    logic       m_cpol;
    logic       m_cpha;
    logic [7:0] m_data_read;

    modport master (
        output m_load,
        output m_start,
        output m_data_to_write,
        output m_slave_address,
        output m_cpol,
        output m_cpha,
        input  m_data_read
    );

    modport slave (
        input  m_load,
        input  m_start,
        input  m_data_to_write,
        input  m_slave_address,
        input  m_cpol,
        input  m_cpha,
        output m_data_read
    );
endinterface

// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one SPI master between N_REQ requesters.
// Define SPI_ARB_FIXED_PRIO_EN to make the lowest-index request always win.
module spi_request_arbiter #(
    parameter int N_REQ       = 3,
    parameter int XFER_CYCLES = 20,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [8*N_REQ-1:0]    req_data,
    input  logic [N_REQ-1:0]      req_cpol,
    input  logic [N_REQ-1:0]      req_cpha,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic [7:0]            rdata,
    output logic                  busy,
    spi_request_arbiter_if.master spi
);

    localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES
                                                         : GAP_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] XFER_LAST = CW'(XFER_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST =
        CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_XFER,
        S_DONE,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CW-1:0]    cnt;
    logic [1:0]       owner;
    logic [1:0]       base;
    logic [1:0]       win;
    logic [7:0]       win_data;
    logic             win_cpol;
    logic             win_cpha;
    logic [7:0]       data_q;
    logic [1:0]       addr_q;
    logic             cpol_q;
    logic             cpha_q;
    logic [7:0]       rdata_q;
    logic [N_REQ-1:0] owner_oh;
    logic             arb_fire;
    logic             xfer_end;
    logic             gap_end;
    logic             owned;

    assign arb_fire = (state == S_IDLE) && (|req);
    assign xfer_end = (state == S_XFER) && (cnt == XFER_LAST);
    assign gap_end  = (state == S_GAP) && (cnt == GAP_LAST);

`ifdef SPI_ARB_FIXED_PRIO_EN
    assign base = 2'd0;
`else
    logic [1:0] ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (state == S_DONE) begin
            ptr <= (owner == 2'(N_REQ - 1)) ? 2'd0 : owner + 2'd1;
        end
    end

    assign base = ptr;
`endif

    // Winner = set request with the smallest distance above base, wrapping.
    always_comb begin
        int best;
        int off;
        best     = N_REQ;
        win      = 2'd0;
        win_data = 8'h00;
        win_cpol = 1'b0;
        win_cpha = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            off = (j >= int'(base)) ? j - int'(base)
                                    : j + N_REQ - int'(base);
            if (req[j] && off < best) begin
                best = off;
                win  = 2'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (win == 2'(j)) begin
                win_data = req_data[8*j +: 8];
                win_cpol = req_cpol[j];
                win_cpha = req_cpha[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (arb_fire) state_d = S_LOAD;
            S_LOAD:  state_d = S_START;
            S_START: state_d = S_XFER;
            S_XFER:  if (xfer_end) state_d = S_DONE;
            S_DONE:  state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:   if (gap_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            owner   <= 2'd0;
            data_q  <= 8'h00;
            addr_q  <= 2'd0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            if (state == S_XFER || state == S_GAP) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (arb_fire) begin
                owner  <= win;
                data_q <= win_data;
                addr_q <= win;
                cpol_q <= win_cpol;
                cpha_q <= win_cpha;
            end
            // Captured on the last XFER edge so rdata is valid with done.
            if (xfer_end) begin
                rdata_q <= spi.m_data_read;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N_REQ; j++) begin
            owner_oh[j] = (owner == 2'(j));
        end
    end

    assign owned = (state == S_LOAD) || (state == S_START) ||
                   (state == S_XFER) || (state == S_DONE);

    assign grant = owned ? owner_oh : '0;
    assign done  = (state == S_DONE) ? owner_oh : '0;
    assign rdata = rdata_q;
    assign busy  = (state != S_IDLE);

    assign spi.m_load          = (state == S_LOAD);
    assign spi.m_start         = (state == S_START);
    assign spi.m_data_to_write = data_q;
    assign spi.m_slave_address = addr_q;
    assign spi.m_cpol          = cpol_q;
    assign spi.m_cpha          = cpha_q;

`ifndef SYNTHESIS
    ap_load_start_excl: assert property (
        @(posedge clk) !(spi.m_load && spi.m_start));
    ap_grant_onehot: assert property (
        @(posedge clk) $onehot0(grant));
`endif

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Directed bench for spi_request_arbiter with a timeline model of the
// expected outputs checked every cycle, plus literal per-scenario checks.
module tb_spi_request_arbiter;
    localparam int N = 3;
    localparam int X = 20;
    localparam int G = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_cpol = '0;
    logic [N-1:0]   req_cpha = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [7:0]     rdata;
    logic           busy;

    spi_request_arbiter_if spi ();

    spi_request_arbiter #(
        .N_REQ(N),
        .XFER_CYCLES(X),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_data(req_data),
        .req_cpol(req_cpol),
        .req_cpha(req_cpha),
        .grant(grant),
        .done(done),
        .rdata(rdata),
        .busy(busy),
        .spi(spi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                         nm, act, exp, cyc);
        end
    endtask

    // SPI master stand-in: returns mosi ^ 0x99, valid X cycles after start.
    logic [7:0] mosi_cap = 8'h00;
    logic [7:0] miso_q = 8'h00;
    int         cd = 0;
    assign spi.m_data_read = miso_q;

    always @(posedge clk) begin
        if (spi.m_load) mosi_cap <= spi.m_data_to_write;
        if (spi.m_start) begin
            cd     <= X;
            miso_q <= ~(mosi_cap ^ 8'h99);
        end else if (cd > 0) begin
            cd <= cd - 1;
            if (cd == 2) miso_q <= mosi_cap ^ 8'h99;
        end
    end

    // Timeline model: one transfer = LOAD at md_tl, DONE at md_tl+X+2.
    bit         md_act = 1'b0;
    int         md_own = 0;
    int         md_tl = 0;
    int         md_free = 0;
    int         md_ptr = 0;
    logic [7:0] md_data = 8'h00;
    logic [7:0] md_rdata = 8'h00;
    logic [1:0] md_addr = 2'd0;
    logic       md_cpol = 1'b0;
    logic       md_cpha = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            md_act   = 1'b0;
            md_ptr   = 0;
            md_own   = 0;
            md_data  = 8'h00;
            md_rdata = 8'h00;
            md_addr  = 2'd0;
            md_cpol  = 1'b0;
            md_cpha  = 1'b0;
            md_free  = cyc + 1;
        end else if (md_act) begin
            if (cyc == md_tl + X + 1) md_rdata = md_data ^ 8'h99;
            if (cyc == md_tl + X + 2) begin
                md_act  = 1'b0;
                md_ptr  = (md_own + 1) % N;
                md_free = cyc + 1 + G;
            end
        end else if (cyc >= md_free && req != '0) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
            md_own = pick(req, 0);
`else
            md_own = pick(req, md_ptr);
`endif
            md_act  = 1'b1;
            md_tl   = cyc + 1;
            md_data = req_data[8*md_own +: 8];
            md_addr = 2'(md_own);
            md_cpol = req_cpol[md_own];
            md_cpha = req_cpha[md_own];
        end
        cyc++;
    end

    logic [N-1:0] e_oh;
    int           e_k;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int j = 0; j < N; j++) e_oh[j] = md_act && (md_own == j);
            e_k = cyc - md_tl;
            chk("grant", 32'(grant), 32'(e_oh));
            chk("done", 32'(done),
                (md_act && e_k == X + 2) ? 32'(e_oh) : 32'd0);
            chk("busy", 32'(busy), 32'(md_act || (cyc < md_free)));
            chk("rdata", 32'(rdata), 32'(md_rdata));
            chk("m_load", 32'(spi.m_load), 32'(md_act && e_k == 0));
            chk("m_start", 32'(spi.m_start), 32'(md_act && e_k == 1));
            chk("m_data", 32'(spi.m_data_to_write), 32'(md_data));
            chk("m_addr", 32'(spi.m_slave_address), 32'(md_addr));
            chk("m_cpol", 32'(spi.m_cpol), 32'(md_cpol));
            chk("m_cpha", 32'(spi.m_cpha), 32'(md_cpha));
        end
    end

    // which: 0 = m_load, 1 = m_start, 2 = any done bit
    task automatic wait_sig(input int which, output int c);
        c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((which == 0 && spi.m_load) || (which == 1 && spi.m_start) ||
                (which == 2 && done != '0)) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_%0d: got timeout expected event", which);
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_load"}, 32'(spi.m_load), 32'd0);
        chk({tag, "_start"}, 32'(spi.m_start), 32'd0);
        chk({tag, "_mdata"}, 32'(spi.m_data_to_write), 32'd0);
        chk({tag, "_addr"}, 32'(spi.m_slave_address), 32'd0);
        chk({tag, "_cpol"}, 32'(spi.m_cpol), 32'd0);
        chk({tag, "_cpha"}, 32'(spi.m_cpha), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    int rc, lc, sc, dc, rr, nd, viol;
    logic [N-1:0] last_done;
    bit got;
`ifdef SPI_ARB_FIXED_PRIO_EN
    int ord[4] = '{0, 0, 0, 0};
    logic [7:0] rd[4] = '{8'h88, 8'h88, 8'h88, 8'h88};
`else
    int ord[4] = '{0, 1, 2, 0};
    logic [7:0] rd[4] = '{8'h88, 8'hBB, 8'hAA, 8'h88};
`endif

    initial begin
        repeat (3) @(negedge clk);
        reset_vals("por");
        rst_n = 1'b1;

        // single request
        @(negedge clk);
        req_data[7:0] = 8'hA5;
        req = 3'b001;
        rc = cyc;
        wait_sig(0, lc);
        chk("t1_req2load", 32'(lc - rc), 32'd1);
        chk("t1_addr", 32'(spi.m_slave_address), 32'd0);
        wait_sig(1, sc);
        chk("t1_load2start", 32'(sc - lc), 32'd1);
        wait_sig(2, dc);
        chk("t1_start2done", 32'(dc - sc), 32'(X + 1));
        chk("t1_done", 32'(done), 32'b001);
        chk("t1_rdata", 32'(rdata), 32'h3C);
        req = '0;
        repeat (6) @(negedge clk);

        // contention, from a fresh pointer
        pulse_reset();
        req_data = {8'h33, 8'h22, 8'h11};
        req = 3'b111;
        dc = 0;
        for (int t = 0; t < 4; t++) begin
            wait_sig(0, lc);
            if (t > 0) chk("t2_gap", 32'(lc - dc), 32'(G + 2));
            chk("t2_addr", 32'(spi.m_slave_address), 32'(ord[t]));
            chk("t2_grant", 32'(grant), 32'(1 << ord[t]));
            wait_sig(2, dc);
            chk("t2_done", 32'(done), 32'(1 << ord[t]));
            chk("t2_rdata", 32'(rdata), 32'(rd[t]));
        end
        req = '0;
        repeat (6) @(negedge clk);

        // config isolation
        req_cpol = 3'b010;
        req_cpha = 3'b010;
        req_data[15:8] = 8'h5A;
        req = 3'b010;
        wait_sig(1, sc);
        viol = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 3) req_data[15:8] = 8'hFF;
            if (!(spi.m_cpol && spi.m_cpha) ||
                spi.m_data_to_write != 8'h5A) viol++;
            if (done != '0) begin
                got = 1'b1;
                break;
            end
        end
        chk("t3_got_done", 32'(got), 32'd1);
        chk("t3_cfg_stable", 32'(viol), 32'd0);
        chk("t3_done", 32'(done), 32'b010);
        chk("t3_mosi", 32'(mosi_cap), 32'h5A);
        chk("t3_rdata", 32'(rdata), 32'hC3);
        req = '0;
        req_cpol = '0;
        req_cpha = '0;
        repeat (6) @(negedge clk);

        // withdrawal after grant
        req_data[23:16] = 8'h77;
        req = 3'b100;
        wait_sig(0, lc);
        repeat (2) @(negedge clk);
        req = '0;
        nd = 0;
        last_done = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done != '0) begin
                nd++;
                last_done = done;
            end
        end
        chk("t4_done_count", 32'(nd), 32'd1);
        chk("t4_done_idx", 32'(last_done), 32'b100);
        chk("t4_rdata", 32'(rdata), 32'hEE);

        // reset mid-transfer
        req_data[15:8] = 8'h42;
        req = 3'b010;
        wait_sig(1, sc);
        while (cyc < sc + 6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        reset_vals("t5_rst");
        rst_n = 1'b1;
        rr = cyc;
        wait_sig(0, lc);
        chk("t5_relaunch", 32'(lc - rr), 32'd1);
        chk("t5_addr", 32'(spi.m_slave_address), 32'd1);
        wait_sig(2, dc);
        chk("t5_done_lat", 32'(dc - lc), 32'(X + 2));
        chk("t5_done", 32'(done), 32'b010);
        chk("t5_rdata", 32'(rdata), 32'hDB);
        req = '0;
        repeat (6) @(negedge clk);

`ifdef SPI_ARB_FIXED_PRIO_EN
        pulse_reset();
        req_data = {8'h33, 8'h22, 8'h11};
        req = 3'b110;
        wait_sig(0, lc);
        chk("t6_first", 32'(spi.m_slave_address), 32'd1);
        req = 3'b111;
        for (int t = 0; t < 2; t++) begin
            wait_sig(0, lc);
            chk("t6_low_wins", 32'(spi.m_slave_address), 32'd0);
        end
        wait_sig(2, dc);
        req = '0;
        repeat (6) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
